// File: rtl/enet_phy_rst_pkg.sv
// Shared definitions for the Ethernet PHY reset sequencer.
//   phy_rst_state_e : sequencer state encoding (2 bits)
//   RST_CNT_W       : width of the software reset counter
//   RST_CNT_MAX     : saturation value of the software reset counter
package enet_phy_rst_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_READY  = 2'd3
    } phy_rst_state_e;

    localparam int                   RST_CNT_W   = 8;
    localparam logic [RST_CNT_W-1:0] RST_CNT_MAX = 8'd255;

endpackage

// File: rtl/enet_phy_reset_seq.sv
// Ethernet PHY reset sequencer.
// Turns the active-low software request level from the PHY reset PIO register
// into a PHY reset pulse of guaranteed minimum width, followed by a settle
// interval, and counts software-initiated sequences (saturating).
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   req_n        in   PIO request level, 0 requests a PHY reset
//   phy_reset_n  out  drives nENET, 0 holds the PHY in reset
//   phy_ready    out  1 once the settle interval has elapsed
//   busy         out  1 whenever the sequencer is not READY
//   reset_count  out  saturating count of software-initiated sequences
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_ASSERT  | PHY held in reset, timer runs to the minimum low width
// ST_HOLD    | minimum width met, PHY kept in reset until req_n returns to 1
// ST_SETTLE  | PHY released, timer runs out the settle interval
// ST_READY   | PHY may be accessed, waiting for the next request
module enet_phy_reset_seq
    import enet_phy_rst_pkg::*;
#(
    parameter int ASSERT_CYCLES = 1000,
    parameter int SETTLE_CYCLES = 5000,
    parameter int CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_n,
    output logic                 phy_reset_n,
    output logic                 phy_ready,
    output logic                 busy,
    output logic [RST_CNT_W-1:0] reset_count
);

    localparam logic [CNT_W-1:0] ASSERT_TC = CNT_W'(ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_TC = CNT_W'(SETTLE_CYCLES - 1);

    phy_rst_state_e       state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [RST_CNT_W-1:0] reset_count_q, reset_count_d;
    logic                 phy_reset_n_q, phy_reset_n_d;
    logic                 phy_ready_q, phy_ready_d;
    logic                 busy_q, busy_d;
    logic                 sw_req;
    logic [CNT_W-1:0]     cnt_inc;

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Timer defaults to 0 so that every state change clears it; states that
    // keep timing load the incremented value explicitly.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        sw_req  = 1'b0;
        case (state_q)
            ST_ASSERT: begin
                if (cnt_q == ASSERT_TC) begin
                    state_d = req_n ? ST_SETTLE : ST_HOLD;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_HOLD: begin
                if (req_n) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // A new request wins over the settle terminal count.
                if (!req_n) begin
                    state_d = ST_ASSERT;
                    sw_req  = 1'b1;
                end else if (cnt_q == SETTLE_TC) begin
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_READY: begin
                if (!req_n) begin
                    state_d = ST_ASSERT;
                    sw_req  = 1'b1;
                end
            end
            default: begin
                state_d = ST_ASSERT;
            end
        endcase
    end

    always_comb begin
        reset_count_d = reset_count_q;
        if (sw_req && (reset_count_q != RST_CNT_MAX)) begin
            reset_count_d = reset_count_q + RST_CNT_W'(1);
        end
    end

    // Outputs are decoded from the next state and registered, so each pin is
    // a plain flop output with no combinational path from req_n.
    always_comb begin
        phy_reset_n_d = (state_d == ST_SETTLE) || (state_d == ST_READY);
        phy_ready_d   = (state_d == ST_READY);
        busy_d        = (state_d != ST_READY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_ASSERT;
            cnt_q         <= '0;
            reset_count_q <= '0;
            phy_reset_n_q <= 1'b0;
            phy_ready_q   <= 1'b0;
            busy_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            reset_count_q <= reset_count_d;
            phy_reset_n_q <= phy_reset_n_d;
            phy_ready_q   <= phy_ready_d;
            busy_q        <= busy_d;
        end
    end

    assign phy_reset_n = phy_reset_n_q;
    assign phy_ready   = phy_ready_q;
    assign busy        = busy_q;
    assign reset_count = reset_count_q;

endmodule
